// File: rtl/npc_sim_pkg.sv
// Shared types and constants for the NPC simulation-top support blocks.
package npc_sim_pkg;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_EBREAK  = 3'd1,
        CAUSE_MMIO    = 3'd2,
        CAUSE_ILLEGAL = 3'd3,
        CAUSE_WDOG    = 3'd4
    } halt_cause_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [31:0] INST_EBREAK   = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL    = 32'h0000_0073;
    localparam logic [31:0] INST_ILL_ZERO = 32'h0000_0000;
    localparam logic [31:0] INST_ILL_ONES = 32'hFFFF_FFFF;

    // Bits needed to hold 0..n; never less than one so zero-valued parameters stay legal.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/npc_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module npc_sat_counter
    import npc_sim_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: clear wins, otherwise step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/npc_trap_monitor.sv
// Halt detector for the NPC simulation top: watches retires and stores, captures the
// first halt condition, gates the CPU and signals the halt to the sim top.
module npc_trap_monitor
    import npc_sim_pkg::*;
#(
    parameter int unsigned      XLEN          = 32,
    parameter int unsigned      CNT_W         = 64,
    parameter logic [XLEN-1:0]  EXIT_ADDR     = 32'ha000_0000,
    parameter int unsigned      WDOG_CYCLES   = 100000,
    parameter int unsigned      DRAIN_CYCLES  = 2,
    parameter bit               ILLEGAL_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   gpr_a0,
    input  logic              mem_wen,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic              run,
    output logic              halt_valid,
    output logic              halt_pulse,
    output logic [2:0]        halt_cause,
    output logic [XLEN-1:0]   exit_code,
    output logic [XLEN-1:0]   trap_pc,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt
);

    localparam int unsigned WDOG_W  = cnt_width(WDOG_CYCLES);
    localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYCLES);

    // Terminal counts; only meaningful when the matching parameter is non-zero.
    localparam logic [WDOG_W-1:0]  WDOG_LAST  =
        (WDOG_CYCLES == 0) ? '0 : WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        (DRAIN_CYCLES == 0) ? '0 : DRAIN_W'(DRAIN_CYCLES - 1);

    state_e              state_q, state_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [XLEN-1:0]     last_pc_q, last_pc_d;
    halt_cause_e         cause_q, cause_d;
    logic [XLEN-1:0]     exit_q, exit_d;
    logic [XLEN-1:0]     trap_pc_q, trap_pc_d;
    logic                pulse_q, pulse_d;

    logic in_run;
    logic ev_ebreak, ev_mmio, ev_illegal, ev_wdog;
    logic capture;

    assign in_run = (state_q == ST_RUN);

    // Halt conditions on the current-cycle inputs; only armed while running.
    always_comb begin
        ev_ebreak  = in_run && inst_valid && (inst == INST_EBREAK);
        ev_mmio    = in_run && mem_wen && (mem_addr == EXIT_ADDR);
        ev_illegal = in_run && ILLEGAL_CHECK && inst_valid &&
                     ((inst == INST_ILL_ZERO) || (inst == INST_ILL_ONES));
        ev_wdog    = in_run && (WDOG_CYCLES != 0) && !inst_valid && (wdog_q == WDOG_LAST);
        capture    = ev_ebreak || ev_mmio || ev_illegal || ev_wdog;
    end

    // Priority-resolve the winning event into the captured fields; otherwise hold.
    always_comb begin
        cause_d   = cause_q;
        exit_d    = exit_q;
        trap_pc_d = trap_pc_q;
        if (ev_ebreak) begin
            cause_d   = CAUSE_EBREAK;
            exit_d    = gpr_a0;
            trap_pc_d = pc;
        end else if (ev_mmio) begin
            cause_d   = CAUSE_MMIO;
            exit_d    = mem_wdata;
            trap_pc_d = inst_valid ? pc : last_pc_q;
        end else if (ev_illegal) begin
            cause_d   = CAUSE_ILLEGAL;
            exit_d    = XLEN'(inst);
            trap_pc_d = pc;
        end else if (ev_wdog) begin
            cause_d   = CAUSE_WDOG;
            exit_d    = {XLEN{1'b1}};
            trap_pc_d = last_pc_q;
        end
    end

    // Watchdog, last-retired PC and drain counter bookkeeping.
    always_comb begin
        wdog_d    = wdog_q;
        last_pc_d = last_pc_q;
        drain_d   = drain_q;
        if (in_run) begin
            drain_d = '0;
            if (inst_valid) begin
                wdog_d    = '0;
                last_pc_d = pc;
            end else if ((WDOG_CYCLES != 0) && (wdog_q != {WDOG_W{1'b1}})) begin
                wdog_d = wdog_q + 1'b1;
            end
        end else if (state_q == ST_DRAIN) begin
            drain_d = drain_q + 1'b1;
        end
    end

    // Next-state logic; HALTED only leaves through reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (capture) begin
                    state_d = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_HALTED;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Pulse is registered from the entry transition so it lines up with the first HALTED cycle.
    assign pulse_d = (state_d == ST_HALTED) && (state_q != ST_HALTED);

    // State and captured-field registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            wdog_q    <= '0;
            drain_q   <= '0;
            last_pc_q <= '0;
            cause_q   <= CAUSE_NONE;
            exit_q    <= '0;
            trap_pc_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            drain_q   <= drain_d;
            last_pc_q <= last_pc_d;
            cause_q   <= cause_d;
            exit_q    <= exit_d;
            trap_pc_q <= trap_pc_d;
            pulse_q   <= pulse_d;
        end
    end

    // State-decoded outputs.
    always_comb begin
        run        = (state_q == ST_RUN);
        halt_valid = (state_q == ST_HALTED);
        halt_pulse = pulse_q;
    end

    assign halt_cause = cause_q;
    assign exit_code  = exit_q;
    assign trap_pc    = trap_pc_q;

    npc_sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (in_run),
        .clr   (1'b0),
        .count (cycle_cnt)
    );

    npc_sat_counter #(
        .W (CNT_W)
    ) u_inst_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (in_run && inst_valid),
        .clr   (1'b0),
        .count (inst_cnt)
    );

endmodule
